// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory and IF/ID bundle of the fetch stage
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - 16-bit RISC fetch stage: PC, IF/ID register, halt/redirect control
// Optional FETCH_PERF_CNT_EN adds fetch_count/flush_count performance counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect,
    input  logic [15:0]      redirect_target,
    fetch_stage_if.master    bus,
    output logic             halted,
    output logic [1:0]       fetch_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [15:0]      flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        capture;
    logic        flush;

    // Instructions are halfword aligned, so redirect targets drop bit 0.
    logic [15:0] target_aligned;
    assign target_aligned = {redirect_target[15:1], 1'b0};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        capture = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (redirect) pc_d = target_aligned;
                if (start)    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d    = target_aligned;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    flush   = valid_q;
                end else if (!stall) begin
                    capture = 1'b1;
                    instr_d = bus.imem_instr;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    if (bus.imem_instr == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_HALTED: begin
                if (redirect) begin
                    pc_d    = target_aligned;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    flush   = valid_q;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ifpc_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (capture && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (flush && flush_cnt_q != 16'hFFFF)        flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = capture ^ flush;
`endif

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifpc_q;
    assign bus.if_id_valid = valid_q;
    assign halted          = (state_q == ST_HALTED);
    assign fetch_state     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic        halted;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (bus),
        .halted          (halted),
        .fetch_state     (fetch_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] imem_model(input logic [15:0] a);
        case (a)
            16'h0000: imem_model = 16'hE188;
            16'h0018: imem_model = 16'hFFFF;
            default:  imem_model = 16'h0000;
        endcase
    endfunction

    assign bus.imem_instr = imem_model(bus.imem_addr);

    typedef struct {
        logic        v;
        logic [15:0] i;
        logic [15:0] p;
        logic [15:0] a;
        logic        h;
        logic [1:0]  s;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec    = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: one expected entry per clock, compared shortly after the edge.
    always @(posedge clk) begin
        exp_t e;
        int   id;
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = vec++;
            chk("if_id_valid", id, {31'd0, bus.if_id_valid}, {31'd0, e.v});
            chk("if_id_instr", id, {16'd0, bus.if_id_instr}, {16'd0, e.i});
            if (e.v) chk("if_id_pc", id, {16'd0, bus.if_id_pc}, {16'd0, e.p});
            chk("imem_addr", id, {16'd0, bus.imem_addr}, {16'd0, e.a});
            chk("halted", id, {31'd0, halted}, {31'd0, e.h});
            chk("fetch_state", id, {30'd0, fetch_state}, {30'd0, e.s});
        end
    end

    task automatic cyc(input logic st, input logic sl, input logic rd, input logic [15:0] tg,
                       input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                       input logic [15:0] ea, input logic eh, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        start = st; stall = sl; redirect = rd; redirect_target = tg;
        e.v = ev; e.i = ei; e.p = ep; e.a = ea; e.h = eh; e.s = es;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 0, {31'd0, bus.if_id_valid}, 32'd0);
        chk({tag, "_instr"}, 0, {16'd0, bus.if_id_instr}, 32'h0);
        chk({tag, "_pc"},    0, {16'd0, bus.if_id_pc}, 32'h0);
        chk({tag, "_addr"},  0, {16'd0, bus.imem_addr}, 32'h0);
        chk({tag, "_halted"},0, {31'd0, halted}, 32'd0);
        chk({tag, "_state"}, 0, {30'd0, fetch_state}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fetch_count"}, 0, fetch_count, 32'd0);
        chk({tag, "_flush_count"}, 0, {16'd0, flush_count}, 32'd0);
`endif
    endtask

    initial begin
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //   st  sl  rd  tgt       v  instr     pc        addr      h  s
        cyc(1, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'hE188, 16'h0000, 16'h0002, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0002, 16'h0004, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0004, 16'h0006, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0006, 16'h0008, 0, 1);
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0006, 16'h0008, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0008, 16'h000A, 0, 1);
        // stall and redirect together: redirect wins, odd target aligned
        cyc(0, 1, 1, 16'h0015,  0, 16'h0000, 16'h0000, 16'h0014, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0014, 16'h0016, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0016, 16'h0018, 0, 1);
        // halt word at 0x18
        cyc(0, 0, 0, 16'h0000,  1, 16'hFFFF, 16'h0018, 16'h0018, 1, 2);
        cyc(0, 1, 0, 16'h0000,  1, 16'hFFFF, 16'h0018, 16'h0018, 1, 2);
        cyc(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0018, 1, 2);
        cyc(1, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0018, 1, 2);
        cyc(0, 0, 1, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'hE188, 16'h0000, 16'h0002, 0, 1);
        // wrap from 0xFFFE to 0
        cyc(0, 0, 1, 16'hFFFE,  0, 16'h0000, 16'h0000, 16'hFFFE, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'hFFFE, 16'h0000, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'hE188, 16'h0000, 16'h0002, 0, 1);
        // halt word visible in same cycle as redirect is discarded
        cyc(0, 0, 1, 16'h0018,  0, 16'h0000, 16'h0000, 16'h0018, 0, 1);
        cyc(0, 0, 1, 16'h0020,  0, 16'h0000, 16'h0000, 16'h0020, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0020, 16'h0022, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0022, 16'h0024, 0, 1);

        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        start = 0; stall = 0; redirect = 0; redirect_target = 16'h0000;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE: hold, redirect loads PC but stays idle, then start
        cyc(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 1, 16'h0030,  0, 16'h0000, 16'h0000, 16'h0030, 0, 0);
        cyc(1, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0030, 0, 1);
        cyc(0, 0, 0, 16'h0000,  1, 16'h0000, 16'h0030, 16'h0032, 0, 1);

        @(negedge clk);
        start = 0; stall = 0; redirect = 0;
        @(negedge clk);
        chk("queue_drained", 0, exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 16-bit RISC pipeline; owns the program counter and drives the combinational instruction memory address.
- Captures the returned 16-bit big-endian instruction into the IF/ID pipeline register for decode.
- Handles start-up, decode stalls, branch/jump redirects and a halt instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch; instructions are 2 bytes.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.
- NOP_WORD, 16'h0000, bubble encoding (add $0,$0,$0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leaves IDLE and begins fetching.
- stall  in  1  hazard stall from decode; freezes PC and IF/ID.
- redirect  in  1  branch taken / jump from a later stage.
- redirect_target  in  16  new PC when redirect=1.
- imem_addr  out  16  address to instruction memory; equals PC.
- imem_instr  in  16  combinational instruction word at imem_addr.
- if_id_instr  out  16  registered instruction.
- if_id_pc  out  16  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  high in HALTED state.
- fetch_state  out  2  IDLE=0, FETCH=1, HALTED=2.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, state=IDLE, halted=0. Reset mid-fetch discards all in-flight state immediately.
- imem_addr = PC in all states; memory is combinational, so fetch latency is 1 cycle (address at edge N, IF/ID holds the word after edge N+1).
- IDLE: PC held, IF/ID holds a bubble. start=1 goes to FETCH on the next edge; the first fetch is from RESET_PC in the following cycle. redirect in IDLE loads PC=target but stays IDLE.
- FETCH, per edge, in priority order:
  1. redirect=1: PC=redirect_target with bit 0 forced to 0; IF/ID gets a bubble (NOP_WORD, valid=0). This holds even with stall=1, since a redirect flushes the stalled wrong-path instruction.
  2. stall=1: PC and all IF/ID registers hold their values.
  3. Otherwise: if_id_instr=imem_instr, if_id_pc=PC, if_id_valid=1, PC=PC+PC_STEP (modulo 2^16; 16'hFFFE wraps to 16'h0000).
- Halt: when case 3 captures imem_instr==HALT_WORD, the halt word is issued to IF/ID with valid=1, PC is not incremented, and the state goes to HALTED.
- HALTED: halted=1, PC frozen; IF/ID becomes a bubble on the first edge with stall=0. stall=1 holds the halt word. redirect=1 loads the target, clears IF/ID and returns to FETCH. start is ignored.
- A halt word captured in the same cycle as redirect is discarded because redirect has priority; the state stays FETCH.
- A redirect target of 16'hFFFE followed by a sequential fetch wraps to 0 with no error.
- No X propagation: every output register has a defined reset value.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output fetch_count[31:0] and output flush_count[15:0], both reset to 0.
  - fetch_count increments on each case-3 capture.
  - flush_count increments on each redirect in FETCH or HALTED that discards a valid IF/ID entry.
  - Both counters saturate at all-ones.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset, then start=1 with imem returning 16'hE188 at 0 and NOP elsewhere -> first valid IF/ID is instr 16'hE188 with pc 0, then pc 2, 4, 6 on consecutive cycles; imem_addr steps by 2.
- stall=1 for 3 cycles while PC=8 -> imem_addr stays 8, IF/ID holds pc 6 with valid=1; after release, the next capture has pc 8.
- stall=1 and redirect=1 together with target 16'h0015 -> PC=16'h0014, IF/ID is a bubble (valid=0, instr 0); the next fetch is from 16'h0014.
- imem returns 16'hFFFF at PC=16'h0018 -> IF/ID gets 16'hFFFF with valid=1, halted=1 next cycle, PC stays 16'h0018, the following cycle is a bubble; redirect to 0 resumes FETCH at 0.
- redirect to 16'hFFFE, then run -> IF/ID pc 16'hFFFE followed by pc 16'h0000.
- Assert rst_n=0 asynchronously mid-cycle during FETCH -> outputs reach reset values before the next clk edge; state=IDLE; with FETCH_PERF_CNT_EN, both counters read 0.
